servo_pwm_io: RTL and testbench
===============================

# servo_pwm_io

Memory-mapped servo PWM controller for the manipulator joints, sitting on the CPU's port-A data bus downstream of the IO address decode, beside the switch input and the 7-segment display latch. The CPU writes per-channel pulse widths in microseconds. The block generates a fixed-period servo frame on each channel. New widths are applied only at frame boundaries, so no output ever produces a truncated or glitched pulse.

## Interface
- `NUM_CH`, 4, number of servo channels (1–8)
- `BASE_ADDR`, 16'hCFF0, address of channel 0; channel i at BASE_ADDR+i, control at BASE_ADDR+NUM_CH
- `TICKS_PER_US`, 50, clk cycles per microsecond (50 MHz)
- `FRAME_US`, 20000, frame period in µs
- `MIN_US`, 500, lowest legal pulse width
- `MAX_US`, 2500, highest legal pulse width
- `RESET_US`, 1500, pulse width after reset
- `SLEW_US`, 20, maximum change per frame; used only with SLEW_LIMIT_EN
- `clk` in 1 — system clock
- `reset` in 1 — asynchronous, active-low reset
- `addr` in 16 — CPU data address
- `wdata` in 16 — CPU write data
- `wren` in 1 — CPU write enable
- `rdata` out 16 — registered read data
- `hit` out 1 — registered; high when the previous-cycle `addr` fell in the block's range (drives the top-level read mux)
- `pwm_out` out NUM_CH — servo outputs
- `frame_tick` out 1 — one-cycle pulse on each frame boundary

## Operation
- **Prescaler:** counts 0..TICKS_PER_US-1. On wrap it asserts `us_tick` internally.
- **Frame counter:** counts 0..FRAME_US-1 in µs and advances on `us_tick`.
- **Frame boundary:** the cycle where `us_tick` is high and the frame counter equals FRAME_US-1. `frame_tick` is high for exactly this cycle.
- **Per-channel registers:** each channel has a `target` and an `active` register, both 16 bits.
- **Channel write:** `wren` with `addr` equal to BASE_ADDR+i stores `wdata` into `target[i]`, clamped to [MIN_US, MAX_US]. The comparison is unsigned, so 0 becomes MIN_US and 16'hFFFF becomes MAX_US.
- **Active update:** at each frame boundary, `active[i]` takes the value of `target[i]`.
- **Output:** `pwm_out[i]` equals `enable` AND (frame counter < `active[i]`).
- **Control register, write:**
  - bit0 sets `enable`.
  - Writing bit1=1 clears the prescaler and frame counter on the next edge, restarting the frame. Bit1 self-clears.
- **Control register, read:** {14'b0, pending, enable}. `pending` is set if any `target[i]` ≠ `active[i]`.
- **Channel read:** returns `active[i]`.
- **Unmapped addresses:** writes are ignored. Reads return 16'h0000 and `hit` stays 0.
- **Enable = 0:** all outputs are low, but the counters and register updates keep running.

## Timing
- **Reset values:**
  - `target` and `active` = RESET_US
  - `enable` = 0
  - counters = 0
  - `pwm_out`, `frame_tick`, `hit` = 0
  - `rdata` = 16'h0000
- **Read latency:** 1 cycle. `rdata` and `hit` are registered from `addr`, matching synchronous RAM read timing.
- **Write latency:** `target` updates on the edge after `wren`.
- **Write on the frame-boundary cycle:** the `active` load uses the pre-write `target`, so the new value takes effect one frame later.
- **Frame restart with simultaneous write:** a restart (ctrl bit1) and a channel write in consecutive cycles are both honoured.
- **Pulse edges:** the pulse rises at frame counter 0 and falls exactly `active`×TICKS_PER_US cycles later.
- **Output register stage:** `pwm_out` is registered, adding 1 cycle of fixed skew that is equal on all channels.
- **Reset mid-frame:** all outputs drop low asynchronously. The next frame starts at counter 0 after `reset` deasserts.

## Configuration
- **`SLEW_LIMIT_EN` defined:** at each frame boundary, `active[i]` moves toward `target[i]` by min(|target−active|, SLEW_US). `pending` stays high until they converge.
- **Not defined:** `active[i]` takes `target[i]` directly. The SLEW_US parameter is unused.

## Structure
- **Package `servo_pwm_pkg`:**
  - register offset constants (channel offset, CTRL offset)
  - CTRL bit indices (enable, restart, pending)
  - pulse-width typedef (16-bit)
- **Sub-module `servo_pwm_channel`:**
  - holds `target` and `active`
  - performs the clamp on write and the slew step
  - implements the compare-to-frame-counter
  - instantiated NUM_CH times in a generate loop
- **Top of block:** owns the prescaler, frame counter, address decode, and read mux.

## Test plan
Bench parameters: TICKS_PER_US=1, FRAME_US=100, MIN_US=10, MAX_US=90, RESET_US=50, SLEW_US=5.

- **Reset:** release `reset`, then write CTRL=1 → every channel pulses 50 cycles high per 100-cycle frame; reading channel 0 returns 50 with `hit`=1 one cycle later.
- **Clamp:** write ch1=3, then ch2=16'hFFFF → after the next `frame_tick`, ch1 is high 10 cycles and ch2 is high 90 cycles; reads return 10 and 90.
- **Boundary write:** write ch0=20 on the `frame_tick` cycle → the following frame is still 50 high, the frame after is 20 high, and `pending` reads 1 in between.
- **Disable/restart:** write CTRL=0 mid-pulse → all outputs low next cycle; write CTRL=3 → frame counter restarts at 0 and pulses resume.
- **Reset mid-frame:** assert `reset` during a high pulse → `pwm_out`=0 immediately and `target` returns to 50; an unmapped read returns 0 with `hit`=0.
- **Slew (SLEW_LIMIT_EN defined):** write ch0=70 from 50 → pulse widths of 55, 60, 65, 70 over four frames, then `pending`=0.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared constants, pulse-width type and clamp helper
// for the servo PWM controller (servo_pwm_io, servo_pwm_channel).
package servo_pwm_pkg;

  typedef logic [15:0] pw_t;

  // channel i sits at BASE_ADDR + CH_OFS + i
  localparam int CH_OFS = 0;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RESTART = 1;
  localparam int CTRL_PENDING = 1;

  // control register follows the last channel
  function automatic int ctrl_ofs(int num_ch);
    return CH_OFS + num_ch;
  endfunction

  function automatic pw_t clamp_pw(pw_t v, pw_t lo, pw_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo channel - target/active width registers,
// clamp on write, frame-boundary load (slew-limited when SLEW_LIMIT_EN).
// Ports: clk, reset (async low), wr/wdata (target write), load (frame
// boundary), fcnt (frame counter, us), en (output enable),
// active (readback), pending (target != active), pwm (registered output).
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int MIN_US   = 500,
  parameter int MAX_US   = 2500,
  parameter int RESET_US = 1500,
  parameter int SLEW_US  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] wdata,
  input  logic        load,
  input  logic [15:0] fcnt,
  input  logic        en,
  output logic [15:0] active,
  output logic        pending,
  output logic        pwm
);

  localparam pw_t LO  = pw_t'(MIN_US);
  localparam pw_t HI  = pw_t'(MAX_US);
  localparam pw_t RST = pw_t'(RESET_US);

  pw_t target_q;
  pw_t active_q;
  pw_t active_d;

`ifdef SLEW_LIMIT_EN
  localparam pw_t SLEW = pw_t'(SLEW_US);

  pw_t diff;
  pw_t step;
  logic up;

  always_comb begin
    up       = target_q > active_q;
    diff     = up ? target_q - active_q
                  : active_q - target_q;
    step     = (diff > SLEW) ? SLEW : diff;
    active_d = up ? active_q + step
                  : active_q - step;
  end
`else
  logic [15:0] unused_slew;

  assign unused_slew = 16'(SLEW_US);
  assign active_d    = target_q;
`endif

  // load sees the pre-write target when wr and load coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q <= RST;
      active_q <= RST;
      pwm      <= 1'b0;
    end else begin
      if (wr)
        target_q <= clamp_pw(wdata, LO, HI);
      if (load)
        active_q <= active_d;
      pwm <= en & (fcnt < active_q);
    end
  end

  assign active  = active_q;
  assign pending = target_q != active_q;

endmodule

// File: rtl/servo_pwm_io.sv
// servo_pwm_io: memory-mapped servo PWM controller. Owns prescaler, frame
// counter, address decode and registered read mux; NUM_CH channel slices.
// Ports: clk, reset (async low), addr/wdata/wren (CPU bus), rdata/hit
// (registered read), pwm_out[NUM_CH], frame_tick (frame boundary pulse).
// Optional feature macro: SLEW_LIMIT_EN (per-frame slew limit on active).
module servo_pwm_io
  import servo_pwm_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter logic [15:0] BASE_ADDR    = 16'hCFF0,
  parameter int          TICKS_PER_US = 50,
  parameter int          FRAME_US     = 20000,
  parameter int          MIN_US       = 500,
  parameter int          MAX_US       = 2500,
  parameter int          RESET_US     = 1500,
  parameter int          SLEW_US      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  input  logic              wren,
  output logic [15:0]       rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick
);

  localparam int PS_W =
    (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PS_W-1:0] PS_LAST =
    PS_W'(TICKS_PER_US - 1);
  localparam logic [15:0] FR_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0] CTRL_OFS = 16'(ctrl_ofs(NUM_CH));

  logic [PS_W-1:0]   presc_q;
  logic [15:0]       fcnt_q;
  logic              us_tick;
  logic              enable_q;
  logic              en_d;
  logic              ctrl_wr;
  logic              restart;
  logic [15:0]       off;
  logic              in_range;
  logic              pending;
  logic [15:0]       rd_d;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] pend_ch;
  pw_t               active [NUM_CH];

  assign us_tick    = presc_q == PS_LAST;
  assign frame_tick = us_tick && (fcnt_q == FR_LAST);

  // offset wraps for addresses below BASE_ADDR, so one compare suffices
  assign off      = addr - BASE_ADDR;
  assign in_range = off <= CTRL_OFS;

  assign ctrl_wr = wren && (off == CTRL_OFS);
  assign restart = ctrl_wr && wdata[CTRL_RESTART];

  // outputs follow an enable write on the very next edge
  assign en_d    = ctrl_wr ? wdata[CTRL_EN] : enable_q;
  assign pending = |pend_ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      fcnt_q  <= '0;
    end else if (restart) begin
      presc_q <= '0;
      fcnt_q  <= '0;
    end else if (us_tick) begin
      presc_q <= '0;
      fcnt_q  <= frame_tick ? 16'd0 : fcnt_q + 16'd1;
    end else begin
      presc_q <= presc_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      enable_q <= 1'b0;
    else if (ctrl_wr)
      enable_q <= wdata[CTRL_EN];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = wren && (off == 16'(CH_OFS + i));

    servo_pwm_channel #(
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .RESET_US (RESET_US),
      .SLEW_US  (SLEW_US)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (ch_wr[i]),
      .wdata   (wdata),
      .load    (frame_tick),
      .fcnt    (fcnt_q),
      .en      (en_d),
      .active  (active[i]),
      .pending (pend_ch[i]),
      .pwm     (pwm_out[i])
    );
  end

  always_comb begin
    rd_d = '0;
    if (off == CTRL_OFS) begin
      rd_d[CTRL_EN]      = enable_q;
      rd_d[CTRL_PENDING] = pending;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (off == 16'(CH_OFS + i))
          rd_d = active[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      hit   <= 1'b0;
    end else begin
      rdata <= rd_d;
      hit   <= in_range;
    end
  end

endmodule

// File: tb/tb_servo_pwm_io.sv
// tb_servo_pwm_io: directed self-checking bench for servo_pwm_io
// (100-cycle frames, 1 tick/us, widths 10..90, reset width 50).
module tb_servo_pwm_io;

  localparam logic [15:0] BASE = 16'hCFF0;
  localparam logic [15:0] CTRL = 16'hCFF4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        wren = 1'b0;
  logic [15:0] rdata;
  logic        hit;
  logic [3:0]  pwm_out;
  logic        frame_tick;

  always #5 clk = ~clk;

  servo_pwm_io #(
    .NUM_CH       (4),
    .BASE_ADDR    (BASE),
    .TICKS_PER_US (1),
    .FRAME_US     (100),
    .MIN_US       (10),
    .MAX_US       (90),
    .RESET_US     (50),
    .SLEW_US      (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .wren       (wren),
    .rdata      (rdata),
    .hit        (hit),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hi_cnt [4];
  logic [15:0] snap;
  logic [15:0] d;
  logic        h;
  int          n;
  bit          got;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    addr = a; wdata = v; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a,
                    output logic [15:0] v, output logic hv);
    @(negedge clk);
    addr = a;
    @(negedge clk);
    v = rdata; hv = hit;
  endtask

  task automatic wait_tick;
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = frame_tick;
    end
    if (!seen) chk("tick_timeout", 32'(frame_tick), 1);
  endtask

  // call right at a frame_tick negedge; counts the frame that follows
  // and snapshots the CTRL readback mid-frame
  task automatic measure;
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        wren = 1'b0;
        addr = CTRL;
      end
      for (int c = 0; c < 4; c++)
        if (pwm_out[c]) hi_cnt[c]++;
      if (i == 50) snap = rdata;
    end
  endtask

  task automatic chk_frame(string tag, int e0, int e1, int e2, int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    measure();
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_ch%0d", tag, c), hi_cnt[c], e[c]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    reset = 1'b1;

    wr(CTRL, 16'd1);
    wait_tick();
    chk_frame("init", 50, 50, 50, 50);
    rd(BASE, d, h);
    chk("init_rd_ch0", 32'(d), 50);
    chk("init_hit", 32'(h), 1);

`ifndef SLEW_LIMIT_EN
    wr(BASE + 16'd1, 16'd3);
    wr(BASE + 16'd2, 16'hFFFF);
    wait_tick();
    chk_frame("clamp", 50, 10, 90, 50);
    chk("clamp_ctrl", 32'(snap), 1);
    rd(BASE + 16'd1, d, h);
    chk("clamp_rd_ch1", 32'(d), 10);
    rd(BASE + 16'd2, d, h);
    chk("clamp_rd_ch2", 32'(d), 90);

    wait_tick();
    addr = BASE; wdata = 16'd20; wren = 1'b1;
    chk_frame("bnd_old", 50, 10, 90, 50);
    chk("bnd_pending", 32'(snap), 3);
    chk_frame("bnd_new", 20, 10, 90, 50);
    chk("bnd_settled", 32'(snap), 1);

    repeat (5) @(negedge clk);
    chk("dis_pre", 32'(pwm_out), 32'hF);
    wr(CTRL, 16'd0);
    chk("dis_low", 32'(pwm_out), 0);
    repeat (3) @(negedge clk);
    chk("dis_hold", 32'(pwm_out), 0);

    wr(CTRL, 16'd3);
    @(negedge clk);
    chk("restart_resume", 32'(pwm_out), 32'hF);
    n = 1; got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      n++;
      got = frame_tick;
    end
    chk("restart_len", 32'(n), 99);
    chk_frame("restart", 20, 10, 90, 50);
    chk("restart_ctrl", 32'(snap), 1);
`else
    wr(BASE, 16'd70);
    wait_tick();
    chk_frame("slew1", 55, 50, 50, 50);
    chk("slew1_pending", 32'(snap), 3);
    chk_frame("slew2", 60, 50, 50, 50);
    chk_frame("slew3", 65, 50, 50, 50);
    chk_frame("slew4", 70, 50, 50, 50);
    chk("slew_done", 32'(snap), 1);
`endif

    wait_tick();
    repeat (5) @(negedge clk);
    chk("mid_pre", 32'(pwm_out), 32'hF);
    #2 reset = 1'b0;
    #1 chk("mid_async", 32'(pwm_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      n++;
      got = frame_tick;
      if (pwm_out != 4'd0) got = 1'b1;
    end
    chk("post_rst_len", 32'(n), 99);
    chk("post_rst_pwm", 32'(pwm_out), 0);
    rd(BASE, d, h);
    chk("post_rst_ch0", 32'(d), 50);
    rd(CTRL, d, h);
    chk("post_rst_ctrl", 32'(d), 0);
    chk("post_rst_ctrl_hit", 32'(h), 1);
    rd(BASE + 16'd5, d, h);
    chk("unmap_hi_data", 32'(d), 0);
    chk("unmap_hi_hit", 32'(h), 0);
    rd(BASE - 16'd1, d, h);
    chk("unmap_lo_data", 32'(d), 0);
    chk("unmap_lo_hit", 32'(h), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
